inst_fetch: RTL and testbench

Instruction-fetch stage. It consumes the PC, branch-prediction bit and PHT index produced by the PC/PCIF pipeline register. It issues one read per PC to the instruction-memory port, with at most one request outstanding. It hands the returned instruction and its prediction metadata to the IF/ID register, and stalls the front end while a fetch is incomplete. On flush it discards the in-flight or stale response so that no wrong-path instruction leaves the stage.

---
 rtl/inst_fetch.sv | 199 +++++++++++++++++++
 tb/tb_inst_fetch.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction-fetch stage. Takes the fetch PC, prediction bit
//                and PHT index from the PC/PCIF register and issues one read
//                per PC to the instruction memory. At most one read is
//                outstanding at any time. Hands the instruction and its
//                metadata to IF/ID, and stalls the front end until the fetch
//                completes. On flush, any in-flight or stale response is
//                dropped so no wrong-path instruction leaves the stage.
//
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                flush                    - pipeline flush
//                stall_next_stage         - IF/ID back-pressure
//                is_branch_taken_in,
//                pht_index_in, pc_in      - fetch request from PCIF
//                rom_en/rom_addr/rom_ready- memory request handshake
//                rom_rvalid/rom_rdata     - memory response
//                stall_req                - front-end stall request
//                valid_out, inst_out,
//                addr_err_out, pc_out,
//                is_branch_taken_out,
//                pht_index_out            - instruction presented to IF/ID
//
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_next_stage,
    input  logic                  is_branch_taken_in,
    input  logic [GHR_WIDTH-1:0]  pht_index_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_ready,
    input  logic                  rom_rvalid,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  stall_req,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic                  addr_err_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  is_branch_taken_out,
    output logic [GHR_WIDTH-1:0]  pht_index_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_taken;
    logic [GHR_WIDTH-1:0]  r_pht_index;
    logic [DATA_WIDTH-1:0] r_inst_buf;

    logic                  w_misaligned;
    logic                  w_meta_load;
    logic                  w_buf_load;
    logic                  w_fwd_meta;
    logic                  w_rom_en;
    logic                  w_valid;
    logic                  w_addr_err;
    logic [DATA_WIDTH-1:0] w_inst;

    assign w_misaligned = |pc_in[1:0];

    // ------------------------------------------------------------------------
    // State, metadata and instruction buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_taken     <= 1'b0;
            r_pht_index <= '0;
            r_inst_buf  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_meta_load) begin
                r_pc        <= pc_in;
                r_taken     <= is_branch_taken_in;
                r_pht_index <= pht_index_in;
            end
            if (w_buf_load) begin
                r_inst_buf <= rom_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and datapath controls
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rom_en     = 1'b0;
        w_valid      = 1'b0;
        w_addr_err   = 1'b0;
        w_inst       = '0;
        w_meta_load  = 1'b0;
        w_buf_load   = 1'b0;
        w_fwd_meta   = 1'b0;

        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!flush) begin
                        if (w_misaligned) begin
                            // No memory access; the error is reported in the
                            // same cycle, so metadata is forwarded from the
                            // inputs while it is being captured.
                            w_valid     = 1'b1;
                            w_addr_err  = 1'b1;
                            w_meta_load = 1'b1;
                            w_fwd_meta  = 1'b1;
                        end else begin
                            w_rom_en = 1'b1;
                            if (rom_ready) begin
                                w_meta_load  = 1'b1;
                                w_state_next = S_WAIT;
                            end
                        end
                    end
                end

                S_WAIT: begin
                    if (flush) begin
                        // A response arriving with the flush is simply dropped;
                        // otherwise it is still in flight and must be absorbed.
                        w_state_next = rom_rvalid ? S_IDLE : S_DISCARD;
                    end else if (rom_rvalid) begin
                        w_valid = 1'b1;
                        w_inst  = rom_rdata;
                        if (stall_next_stage) begin
                            w_buf_load   = 1'b1;
                            w_state_next = S_HOLD;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end

                S_HOLD: begin
                    w_valid = 1'b1;
                    w_inst  = r_inst_buf;
                    if (!stall_next_stage || flush) begin
                        w_state_next = S_IDLE;
                    end
                end

                S_DISCARD: begin
                    if (rom_rvalid) begin
                        w_state_next = S_IDLE;
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase

            // Nothing is ever presented while the pipeline is being flushed.
            if (flush) begin
                w_valid    = 1'b0;
                w_addr_err = 1'b0;
                w_inst     = '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_en       = w_rom_en;
    assign rom_addr     = pc_in;
    assign valid_out    = w_valid;
    assign inst_out     = w_inst;
    assign addr_err_out = w_addr_err;

    // Stall drops during flush so the PC register can load the redirect target.
    assign stall_req = !rst && !(w_valid && !stall_next_stage) && !flush;

    assign pc_out              = rst ? '0   : (w_fwd_meta ? pc_in              : r_pc);
    assign is_branch_taken_out = rst ? 1'b0 : (w_fwd_meta ? is_branch_taken_in : r_taken);
    assign pht_index_out       = rst ? '0   : (w_fwd_meta ? pht_index_in       : r_pht_index);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch. Directed scenarios
//                followed by randomized PCIF/memory behaviour, checked against
//                a transaction-level model of what the stage must present.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int AW = 32;
    localparam int GW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          stall_next_stage;
    logic          is_branch_taken_in;
    logic [GW-1:0] pht_index_in;
    logic [AW-1:0] pc_in;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic          rom_ready;
    logic          rom_rvalid;
    logic [DW-1:0] rom_rdata;
    logic          stall_req;
    logic          valid_out;
    logic [DW-1:0] inst_out;
    logic          addr_err_out;
    logic [AW-1:0] pc_out;
    logic          is_branch_taken_out;
    logic [GW-1:0] pht_index_out;

    int            checks;
    int            errors;

    // PCIF model state
    logic          prev_deliv;
    logic          prev_flush;
    logic [AW-1:0] flush_target;
    int            idle_cnt;

    // Memory model state
    int            mem_lat;
    logic          m_pend;
    int            m_cnt;
    logic [AW-1:0] m_addr;

    inst_fetch #(
        .ADDR_WIDTH (AW),
        .GHR_WIDTH  (GW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .stall_next_stage    (stall_next_stage),
        .is_branch_taken_in  (is_branch_taken_in),
        .pht_index_in        (pht_index_in),
        .pc_in               (pc_in),
        .rom_en              (rom_en),
        .rom_addr            (rom_addr),
        .rom_ready           (rom_ready),
        .rom_rvalid          (rom_rvalid),
        .rom_rdata           (rom_rdata),
        .stall_req           (stall_req),
        .valid_out           (valid_out),
        .inst_out            (inst_out),
        .addr_err_out        (addr_err_out),
        .pc_out              (pc_out),
        .is_branch_taken_out (is_branch_taken_out),
        .pht_index_out       (pht_index_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: reset vector holds a known word, every
    // other address returns a value unique in its low 16 address bits.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'hbfc0_0000) return 32'h2408_0001;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // Memory: accepts on rom_en && rom_ready, answers after mem_lat cycles.
    always @(posedge clk) begin
        if (rst) begin
            m_pend     <= 1'b0;
            m_cnt      <= 0;
            m_addr     <= '0;
            rom_rvalid <= 1'b0;
            rom_rdata  <= '0;
        end else begin
            rom_rvalid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    rom_rvalid <= 1'b1;
                    rom_rdata  <= memf(m_addr);
                    m_pend     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (rom_en && rom_ready) begin
                m_addr <= rom_addr;
                if (mem_lat == 1) begin
                    rom_rvalid <= 1'b1;
                    rom_rdata  <= memf(rom_addr);
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= mem_lat - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_meta();
        is_branch_taken_in = 1'($urandom_range(0, 1));
        pht_index_in       = GW'($urandom_range(0, 31));
    endtask

    // Advance one clock; PCIF loads the redirect target after a flush, the
    // next sequential PC after a delivery, and otherwise holds its PC.
    task automatic step();
        @(posedge clk);
        #1;
        if (prev_flush) begin
            pc_in = flush_target;
            new_meta();
        end else if (prev_deliv) begin
            pc_in = (pc_in[1:0] != 2'b00) ? ({pc_in[31:2], 2'b00} + 32'd4) : (pc_in + 32'd4);
            new_meta();
        end
    endtask

    // Rules that must hold in every out-of-reset cycle.
    task automatic model_check();
        logic mis;
        logic outst;
        logic deliv;
        mis   = (pc_in[1:0] != 2'b00);
        outst = m_pend || rom_rvalid;
        deliv = valid_out && !stall_next_stage;
        chk("rom_en_illegal", 32'(rom_en && (flush || outst || mis)), 32'd0);
        if (rom_en) chk("rom_addr", rom_addr, pc_in);
        if (flush) chk("valid_in_flush", 32'(valid_out), 32'd0);
        chk("stall_req", 32'(stall_req), 32'(!deliv && !flush));
        if (valid_out) begin
            chk("m_pc_out", pc_out, pc_in);
            chk("m_taken", 32'(is_branch_taken_out), 32'(is_branch_taken_in));
            chk("m_pht", 32'(pht_index_out), 32'(pht_index_in));
            chk("m_addr_err", 32'(addr_err_out), 32'(mis));
            chk("m_inst", inst_out, mis ? 32'd0 : memf(pc_in));
        end else begin
            chk("addr_err_idle", 32'(addr_err_out), 32'd0);
        end
        if (deliv || flush) idle_cnt = 0;
        else idle_cnt++;
        chk("liveness", 32'(idle_cnt <= 60), 32'd1);
    endtask

    task automatic settle();
        #4;
        if (rst) begin
            chk("rst_rom_en", 32'(rom_en), 32'd0);
            chk("rst_valid", 32'(valid_out), 32'd0);
            idle_cnt = 0;
        end else begin
            model_check();
        end
        prev_deliv = valid_out && !stall_next_stage;
        prev_flush = flush && !rst;
    endtask

    initial begin
        int r;
        checks             = 0;
        errors             = 0;
        rst                = 1'b1;
        flush              = 1'b0;
        stall_next_stage   = 1'b0;
        rom_ready          = 1'b1;
        mem_lat            = 1;
        pc_in              = 32'hbfc0_0000;
        is_branch_taken_in = 1'b1;
        pht_index_in       = 5'h15;
        flush_target       = '0;
        prev_deliv         = 1'b0;
        prev_flush         = 1'b0;
        idle_cnt           = 0;

        // Reset state
        repeat (3) begin step(); settle(); end
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        chk("rst_addr_err", 32'(addr_err_out), 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_taken", 32'(is_branch_taken_out), 32'd0);
        chk("rst_pht", 32'(pht_index_out), 32'd0);

        // Reset release, latency-1 fetch of the reset vector
        step(); rst = 1'b0; settle();
        chk("t1_rom_en", 32'(rom_en), 32'd1);
        chk("t1_rom_addr", rom_addr, 32'hbfc0_0000);
        chk("t1_stall_req", 32'(stall_req), 32'd1);
        step(); settle();
        chk("t1_valid", 32'(valid_out), 32'd1);
        chk("t1_inst", inst_out, 32'h2408_0001);
        chk("t1_pc_out", pc_out, 32'hbfc0_0000);
        chk("t1_stall_deliv", 32'(stall_req), 32'd0);
        step(); settle();
        chk("t1_next_en", 32'(rom_en), 32'd1);
        chk("t1_next_addr", rom_addr, 32'hbfc0_0004);
        step(); settle();
        chk("t1_next_inst", inst_out, memf(32'hbfc0_0004));

        // rom_ready low for three cycles
        for (int i = 0; i < 3; i++) begin
            step(); rom_ready = 1'b0; settle();
            chk("t2_en_held", 32'(rom_en), 32'd1);
            chk("t2_addr_held", rom_addr, 32'hbfc0_0008);
            chk("t2_stall", 32'(stall_req), 32'd1);
        end
        step(); rom_ready = 1'b1; settle();
        chk("t2_en_ready", 32'(rom_en), 32'd1);
        step(); settle();
        chk("t2_valid", 32'(valid_out), 32'd1);
        chk("t2_inst", inst_out, memf(32'hbfc0_0008));

        // IF/ID back-pressure for four cycles from rvalid
        step(); settle();
        chk("t3_addr", rom_addr, 32'hbfc0_000c);
        step(); stall_next_stage = 1'b1; settle();
        chk("t3_valid_rv", 32'(valid_out), 32'd1);
        chk("t3_stall_rv", 32'(stall_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            chk("t3_hold_valid", 32'(valid_out), 32'd1);
            chk("t3_hold_inst", inst_out, memf(32'hbfc0_000c));
            chk("t3_hold_no_en", 32'(rom_en), 32'd0);
        end
        step(); stall_next_stage = 1'b0; settle();
        chk("t3_deliv_inst", inst_out, memf(32'hbfc0_000c));
        chk("t3_deliv_stall", 32'(stall_req), 32'd0);

        // Flush one cycle after acceptance, memory latency 3
        step(); mem_lat = 3; settle();
        chk("t4_addr", rom_addr, 32'hbfc0_0010);
        step(); flush = 1'b1; flush_target = 32'hbfc0_0000; settle();
        chk("t4_flush_valid", 32'(valid_out), 32'd0);
        chk("t4_flush_stall", 32'(stall_req), 32'd0);
        step(); flush = 1'b0; settle();
        chk("t4_disc_en", 32'(rom_en), 32'd0);
        chk("t4_disc_stall", 32'(stall_req), 32'd1);
        step(); settle();
        chk("t4_drop_valid", 32'(valid_out), 32'd0);
        chk("t4_drop_en", 32'(rom_en), 32'd0);
        step(); mem_lat = 1; settle();
        chk("t4_new_en", 32'(rom_en), 32'd1);
        chk("t4_new_addr", rom_addr, 32'hbfc0_0000);
        step(); settle();
        chk("t4_new_inst", inst_out, 32'h2408_0001);
        chk("t4_new_pc", pc_out, 32'hbfc0_0000);

        // Flush coincident with rvalid
        step(); settle();
        chk("t5_addr", rom_addr, 32'hbfc0_0004);
        step(); flush = 1'b1; flush_target = 32'hbfc0_0100; settle();
        chk("t5_valid", 32'(valid_out), 32'd0);
        step(); flush = 1'b0; settle();
        chk("t5_new_en", 32'(rom_en), 32'd1);
        chk("t5_new_addr", rom_addr, 32'hbfc0_0100);
        step(); settle();
        chk("t5_inst", inst_out, memf(32'hbfc0_0100));

        // Misaligned fetch
        step(); flush = 1'b1; flush_target = 32'hbfc0_0002; settle();
        step(); flush = 1'b0; settle();
        chk("t6_no_en", 32'(rom_en), 32'd0);
        chk("t6_valid", 32'(valid_out), 32'd1);
        chk("t6_addr_err", 32'(addr_err_out), 32'd1);
        chk("t6_inst", inst_out, 32'd0);
        chk("t6_pc_out", pc_out, 32'hbfc0_0002);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            r     = int'($urandom_range(0, 99));
            rst   = (r == 0);
            flush = !rst && (r >= 1) && (r <= 8);
            if (flush) begin
                flush_target = 32'hbfc0_0000 + ($urandom_range(0, 1023) << 2);
                if ($urandom_range(0, 7) == 0) flush_target = flush_target + $urandom_range(1, 3);
            end
            stall_next_stage = ($urandom_range(0, 2) == 0);
            rom_ready        = ($urandom_range(0, 3) != 0);
            mem_lat          = int'($urandom_range(1, 4));
            settle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
